// File: rtl/eth_tx_frame_ctrl.sv
// GMII transmit sequencer: preamble, SFD, payload, zero pad, FCS, inter-frame gap.
// Drives an external byte-wide CRC32 engine and inserts its result as the FCS.
module eth_tx_frame_ctrl #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_CYCLES   = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic        crc_init,
   output logic        crc_en,
   output logic [7:0]  crc_data,
   input  logic [31:0] crc_result,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic        busy,
   output logic        underrun
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_SFD      = 3'd2;
   localparam logic [2:0] S_PAYLOAD  = 3'd3;
   localparam logic [2:0] S_PAD      = 3'd4;
   localparam logic [2:0] S_FCS      = 3'd5;
   localparam logic [2:0] S_IFG      = 3'd6;
   localparam logic [2:0] S_DROP     = 3'd7;

   // Small phase counter shared by preamble, FCS and IFG; parameters are assumed < 256.
   localparam logic [7:0]  L_PRE = 8'(PREAMBLE_LEN);
   localparam logic [7:0]  L_IFG = 8'(IFG_CYCLES);
   localparam logic [11:0] L_MIN = 12'(MIN_FRAME);

   logic [2:0]  r_state, w_state;
   logic [7:0]  r_cnt, w_cnt, w_cnt_inc;
   logic [10:0] r_bcnt, w_bcnt, w_bcnt_inc;
   logic [11:0] w_bcnt_nxt;
   logic [31:0] r_fcs, w_fcs;
   logic [7:0]  r_txd, w_txd;
   logic        r_tx_en, w_tx_en;
   logic        r_tx_er, w_tx_er;
   logic        r_busy;
   logic        r_underrun, w_underrun;
   logic        r_crc_init, w_crc_init;

   assign gmii_txd   = r_txd;
   assign gmii_tx_en = r_tx_en;
   assign gmii_tx_er = r_tx_er;
   assign busy       = r_busy;
   assign underrun   = r_underrun;
   assign crc_init   = r_crc_init;

   assign w_cnt_inc  = r_cnt + 8'd1;
   // Byte counter saturates; the unsaturated sum is only used for the MIN_FRAME compare.
   assign w_bcnt_inc = (&r_bcnt) ? r_bcnt : r_bcnt + 11'd1;
   assign w_bcnt_nxt = {1'b0, r_bcnt} + 12'd1;

   // Handshake and CRC feed are combinational so an accepted byte hits the engine the same cycle.
   always_comb begin
      s_ready  = (r_state == S_PAYLOAD) || (r_state == S_DROP);
      crc_en   = ((r_state == S_PAYLOAD) && s_valid) || (r_state == S_PAD);
      crc_data = (r_state == S_PAYLOAD) ? s_data : 8'h00;
   end

   // Next state and next registered outputs; each state decides the byte on the wire next cycle.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_bcnt     = r_bcnt;
      w_fcs      = r_fcs;
      w_txd      = 8'h00;
      w_tx_en    = 1'b0;
      w_tx_er    = 1'b0;
      w_underrun = 1'b0;
      w_crc_init = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s_valid) begin
               w_txd   = 8'h55;
               w_tx_en = 1'b1;
               w_cnt   = 8'd1;
               if (L_PRE > 8'd1) begin
                  w_state = S_PREAMBLE;
               end else begin
                  w_state    = S_SFD;
                  w_crc_init = 1'b1;
               end
            end
         end
         S_PREAMBLE: begin
            w_txd   = 8'h55;
            w_tx_en = 1'b1;
            w_cnt   = w_cnt_inc;
            if (w_cnt_inc >= L_PRE) begin
               w_state    = S_SFD;
               w_crc_init = 1'b1;
            end
         end
         S_SFD: begin
            w_txd   = 8'hD5;
            w_tx_en = 1'b1;
            w_state = S_PAYLOAD;
            w_cnt   = 8'd0;
            w_bcnt  = 11'd0;
         end
         S_PAYLOAD: begin
            w_tx_en = 1'b1;
            if (s_valid) begin
               w_txd  = s_data;
               w_bcnt = w_bcnt_inc;
               if (s_last) begin
                  w_state = (w_bcnt_nxt < L_MIN) ? S_PAD : S_FCS;
                  w_cnt   = 8'd0;
               end
            end else begin
               // Source starved mid-frame: poison the frame with one error byte.
               w_tx_er    = 1'b1;
               w_underrun = 1'b1;
               w_state    = S_DROP;
            end
         end
         S_PAD: begin
            w_tx_en = 1'b1;
            w_bcnt  = w_bcnt_inc;
            if (w_bcnt_nxt >= L_MIN) begin
               w_state = S_FCS;
               w_cnt   = 8'd0;
            end
         end
         S_FCS: begin
            // First cycle reads the engine directly and captures the rest; later bytes shift out.
            w_tx_en = 1'b1;
            w_cnt   = w_cnt_inc;
            if (r_cnt == 8'd0) begin
               w_txd = crc_result[31:24];
               w_fcs = {crc_result[23:0], 8'h00};
            end else begin
               w_txd = r_fcs[31:24];
               w_fcs = {r_fcs[23:0], 8'h00};
            end
            if (r_cnt == 8'd3) begin
               w_state = S_IFG;
               w_cnt   = 8'd0;
            end
         end
         S_IFG: begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc >= L_IFG) begin
               w_state = S_IDLE;
               w_cnt   = 8'd0;
            end
         end
         S_DROP: begin
            if (s_valid && s_last) begin
               w_state = S_IFG;
               w_cnt   = 8'd0;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_bcnt     <= 11'd0;
         r_fcs      <= 32'd0;
         r_txd      <= 8'h00;
         r_tx_en    <= 1'b0;
         r_tx_er    <= 1'b0;
         r_busy     <= 1'b0;
         r_underrun <= 1'b0;
         r_crc_init <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_bcnt     <= w_bcnt;
         r_fcs      <= w_fcs;
         r_txd      <= w_txd;
         r_tx_en    <= w_tx_en;
         r_tx_er    <= w_tx_er;
         r_busy     <= (w_state != S_IDLE);
         r_underrun <= w_underrun;
         r_crc_init <= w_crc_init;
      end
   end

endmodule
